// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/visible decode and aligned delay line
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       visible_d
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Inactive {hsync, vsync, visible}, loaded into every delay stage on reset
  localparam logic [2:0] IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  logic hs_act, vs_act;

  always_comb begin
    hs_act      = (hc_q >= HS_FIRST) && (hc_q <= HS_LAST);
    vs_act      = (vc_q >= VS_FIRST) && (vc_q <= VS_LAST);
    hsync       = hs_act ? SYNC_POL : ~SYNC_POL;
    vsync       = vs_act ? SYNC_POL : ~SYNC_POL;
    visible     = (hc_q < H_VIS) && (vc_q < V_VIS);
    line_start  = pix_en && (hc_q == '0);
    frame_start = pix_en && (hc_q == '0) && (vc_q == '0);
  end

  assign hc = hc_q;
  assign vc = vc_q;

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign {hsync_d, vsync_d, visible_d} = {hsync, vsync, visible};
    end else begin : g_delay
      logic [2:0] pipe_q [PIPE_DELAY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= IDLE;
        end else if (pix_en) begin
          pipe_q[0] <= {hsync, vsync, visible};
          for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign {hsync_d, vsync_d, visible_d} = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized scoreboard bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] a_hc, a_vc, b_hc, b_vc;
  logic a_vis, a_hs, a_vs, a_ls, a_fs, a_hsd, a_vsd, a_visd;
  logic b_vis, b_hs, b_vs, b_ls, b_fs, b_hsd, b_vsd, b_visd;

  // Standard 640x480 timing, active-low sync, two-tick delay
  vga_timing_gen #(
    .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .SYNC_POL(1'b0), .PIPE_DELAY(2)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hc(a_hc), .vc(a_vc), .visible(a_vis), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs),
    .hsync_d(a_hsd), .vsync_d(a_vsd), .visible_d(a_visd)
  );

  // Tiny raster so whole frames fit in the run, active-high sync, no delay
  vga_timing_gen #(
    .H_VISIBLE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hc(b_hc), .vc(b_vc), .visible(b_vis), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs),
    .hsync_d(b_hsd), .vsync_d(b_vsd), .visible_d(b_visd)
  );

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic vis, hs, vs, ls, fs, hsd, vsd, visd;
  } obs_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, d;
    bit pol;
  } cfg_t;

  obs_t q_a[$];
  obs_t q_b[$];
  int checks = 0;
  int passed = 0;
  int ticks_a = 0;
  int ticks_b = 0;

  // {hsync, vsync, visible} of the pixel reached after t ticks since reset
  function automatic logic [2:0] raster(input cfg_t c, input int t);
    int ht, vt, h, v;
    logic hs, vs, vis;
    ht  = c.hv + c.hf + c.hs + c.hb;
    vt  = c.vv + c.vf + c.vs + c.vb;
    h   = t % ht;
    v   = (t / ht) % vt;
    hs  = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.pol : !c.pol;
    vs  = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.pol : !c.pol;
    vis = (h < c.hv) && (v < c.vv);
    return {hs, vs, vis};
  endfunction

  function automatic obs_t model(input cfg_t c, input int t, input bit en);
    obs_t o;
    int ht, vt, h, v;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    h  = t % ht;
    v  = (t / ht) % vt;
    o.hc = 10'(h);
    o.vc = 10'(v);
    {o.hs, o.vs, o.vis} = raster(c, t);
    o.ls = en && (h == 0);
    o.fs = en && (h == 0) && (v == 0);
    if (t >= c.d) {o.hsd, o.vsd, o.visd} = raster(c, t - c.d);
    else          {o.hsd, o.vsd, o.visd} = {!c.pol, !c.pol, 1'b0};
    return o;
  endfunction

  cfg_t cfg_a = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, d:2, pol:1'b0};
  cfg_t cfg_b = '{hv:6, hf:2, hs:3, hb:2, vv:4, vf:2, vs:2, vb:1, d:0, pol:1'b1};

  // One clock of stimulus: drive inputs, queue expected outputs, advance the model
  task automatic step(input bit r, input bit en);
    rst    = r;
    pix_en = en;
    if (!r) begin
      ticks_a = 0;
      ticks_b = 0;
    end
    q_a.push_back(model(cfg_a, ticks_a, en));
    q_b.push_back(model(cfg_b, ticks_b, en));
    if (r && en) begin
      ticks_a++;
      ticks_b++;
    end
    @(negedge clk);
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t actual hc=%0d vc=%0d vis/hs/vs/ls/fs/hsd/vsd/visd=%b required hc=%0d vc=%0d vis/hs/vs/ls/fs/hsd/vsd/visd=%b",
                  name, $time, act.hc, act.vc, act[7:0], exp.hc, exp.vc, exp[7:0]);
  endtask

  initial begin : monitor
    obs_t act;
    forever begin
      @(negedge clk);
      #1;
      if (q_a.size() > 0) begin
        act = '{a_hc, a_vc, a_vis, a_hs, a_vs, a_ls, a_fs, a_hsd, a_vsd, a_visd};
        compare("dut_a", act, q_a.pop_front());
      end
      if (q_b.size() > 0) begin
        act = '{b_hc, b_vc, b_vis, b_hs, b_vs, b_ls, b_fs, b_hsd, b_vsd, b_visd};
        compare("dut_b", act, q_b.pop_front());
      end
    end
  end

  initial begin : driver
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, i[0]);
    // Full-rate ticks up to hc=700 of line 1, inside hsync
    while (ticks_a < 1500) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    // One tick in four
    for (int i = 0; i < 3600; i++) step(1'b1, (i % 4) == 3);
    // Random enable density with rare mid-line resets
    for (int i = 0; i < 20000; i++)
      step(($urandom_range(0, 2999) != 0), ($urandom_range(0, 9) < 7));
    for (int i = 0; i < 3; i++) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
